instr_encoder: RTL

- Streaming RISC-V instruction encoder and loader. It is the inverse of the opcode-to-immediate-format decode path.
- Accepts field-level instruction requests (format, opcode, registers, funct, full-width immediate) over a valid/ready handshake.
- Range-checks the immediate, packs it into the format-specific bit layout, and writes the 32-bit word into instruction memory at an auto-incrementing address.
- Used by the bench/boot path to load programs into imem without hand-assembled hex.

---
 rtl/instr_encoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder : packs field-level RISC-V requests into 32-bit words and
//                 streams them into imem at an auto-incrementing address.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt_sel,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err_range,
  output logic              err_fmt
);

  localparam logic [2:0]        c_fmt_i = 3'd0;
  localparam logic [2:0]        c_fmt_b = 3'd1;
  localparam logic [2:0]        c_fmt_u = 3'd2;
  localparam logic [2:0]        c_fmt_s = 3'd3;
  localparam logic [2:0]        c_fmt_j = 3'd4;
  localparam logic [2:0]        c_fmt_r = 3'd5;
  localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              erng_q, erng_d;
  logic              efmt_q, efmt_d;

  logic        w_accept;
  logic        w_fmt_ok;
  logic        w_imm_ok;
  logic [24:0] w_body;

  // count never exceeds capacity, so its MSB alone marks "full"
  assign full      = count_q[ADDR_W];
  assign in_ready  = ~full & ~start;
  assign w_accept  = in_valid & in_ready;
  assign w_fmt_ok  = (fmt_sel <= c_fmt_r);

  // Range checks expressed as "upper bits are pure sign extension"
  always_comb begin
    w_imm_ok = 1'b1;
    case (fmt_sel)
      c_fmt_i, c_fmt_s: w_imm_ok = (&imm[31:11]) | ~(|imm[31:11]);
      c_fmt_b:          w_imm_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      c_fmt_j:          w_imm_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      c_fmt_u:          w_imm_ok = ~(|imm[11:0]);
      default:          w_imm_ok = 1'b1;
    endcase
  end

  always_comb begin
    w_body = '0;
    case (fmt_sel)
      c_fmt_i: w_body = {imm[11:0], rs1, funct3, rd};
      c_fmt_s: w_body = {imm[11:5], rs2, rs1, funct3, imm[4:0]};
      c_fmt_b: w_body = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11]};
      c_fmt_u: w_body = {imm[31:12], rd};
      c_fmt_j: w_body = {imm[20], imm[10:1], imm[11], imm[19:12], rd};
      c_fmt_r: w_body = {funct7, rs2, rs1, funct3, rd};
      default: w_body = '0;
    endcase
  end

  always_comb begin
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    erng_d  = erng_q;
    efmt_d  = efmt_q;
    if (start) begin
      count_d = '0;
      erng_d  = 1'b0;
      efmt_d  = 1'b0;
    end else if (w_accept) begin
      if (!w_fmt_ok) begin
        efmt_d = 1'b1;
      end else if (!w_imm_ok) begin
        erng_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = c_base + count_q[ADDR_W-1:0];
        wdata_d = {w_body, opcode};
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= c_base;
      wdata_q <= '0;
      count_q <= '0;
      erng_q  <= 1'b0;
      efmt_q  <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      erng_q  <= erng_d;
      efmt_q  <= efmt_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err_range  = erng_q;
  assign err_fmt    = efmt_q;

endmodule

`default_nettype wire
